// File: rtl/chan_start_sequencer.sv
// chan_start_sequencer: turns software arm/abort commands into a frame-aligned run window and frame counter.
// Define CHAN_START_SYNC_TIMEOUT_EN to abandon ARMED/DELAY after TMO_CYC cycles without sync_in.
module chan_start_sequencer #(
   parameter int CNT_W   = 32,
   parameter int TMO_CYC = 1 << 24
) (
   input  logic             user_clk,
   input  logic             user_rst_n,
   input  logic [31:0]      ctrl_in,
   input  logic             sync_in,
   output logic             start_pulse,
   output logic             run,
   output logic             armed,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [31:0]      status_out
);
   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DELAY = 2'd2, RUN = 2'd3} state_t;
   state_t           state_q, state_d;
   logic             arm_q, arm_prev_q, abort_q;
   logic [15:0]      dly_in_q, dcnt_q, dcnt_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             start_pulse_q, start_pulse_d, run_q, run_d, armed_q, armed_d;
   logic             tmo_flag_q, tmo_flag_d;
   logic             arm_rise, waiting, tmo_hit, unused_ok;
   assign arm_rise = arm_q & ~arm_prev_q;
   assign waiting  = state_q == ARMED || state_q == DELAY;
`ifdef CHAN_START_SYNC_TIMEOUT_EN
   localparam int TMO_W = $clog2(TMO_CYC);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   assign tmo_hit   = waiting && !sync_in && tmo_q == TMO_W'(TMO_CYC - 1);
   assign unused_ok = ^ctrl_in[15:2];
   always_comb begin
      tmo_d = (waiting && !sync_in && !abort_q) ? tmo_q + TMO_W'(1) : '0;
   end
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) tmo_q <= '0;
      else             tmo_q <= tmo_d;
   end
`else
   assign tmo_hit   = 1'b0;
   assign unused_ok = ^{ctrl_in[15:2], TMO_CYC[0]};
`endif
   // dcnt counts remaining syncs before RUN, so ARMED and DELAY share one rule
   always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      frame_cnt_d = frame_cnt_q;
      tmo_flag_d  = tmo_flag_q;
      if (abort_q) state_d = IDLE;
      else if (state_q == IDLE) begin
         if (arm_rise) begin
            state_d    = ARMED;
            dcnt_d     = dly_in_q;
            tmo_flag_d = 1'b0;
         end
      end else if (waiting) begin
         if (sync_in) begin
            state_d = dcnt_q == '0 ? RUN : DELAY;
            dcnt_d  = dcnt_q - 16'd1;
         end else if (tmo_hit) begin
            state_d    = IDLE;
            tmo_flag_d = 1'b1;
         end
      end else if (sync_in) frame_cnt_d = frame_cnt_q + CNT_W'(1);
      start_pulse_d = state_d == RUN && state_q != RUN;
      if (start_pulse_d) frame_cnt_d = '0;
      run_d   = state_d == RUN;
      armed_d = state_d == ARMED || state_d == DELAY;
   end
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         arm_q         <= 1'b0;
         arm_prev_q    <= 1'b0;
         abort_q       <= 1'b0;
         dly_in_q      <= '0;
         state_q       <= IDLE;
         dcnt_q        <= '0;
         frame_cnt_q   <= '0;
         start_pulse_q <= 1'b0;
         run_q         <= 1'b0;
         armed_q       <= 1'b0;
         tmo_flag_q    <= 1'b0;
      end else begin
         arm_q         <= ctrl_in[0];
         arm_prev_q    <= arm_q;
         abort_q       <= ctrl_in[1];
         dly_in_q      <= ctrl_in[31:16];
         state_q       <= state_d;
         dcnt_q        <= dcnt_d;
         frame_cnt_q   <= frame_cnt_d;
         start_pulse_q <= start_pulse_d;
         run_q         <= run_d;
         armed_q       <= armed_d;
         tmo_flag_q    <= tmo_flag_d;
      end
   end
   assign start_pulse = start_pulse_q;
   assign run         = run_q;
   assign armed       = armed_q;
   assign frame_cnt   = frame_cnt_q;
   assign status_out  = {state_q, tmo_flag_q, 13'b0, frame_cnt_q[15:0]};
endmodule
